sys_array_feeder: RTL and testbench
===================================

// Module: sys_array_feeder
// PURPOSE
//  Upstream stage of the systolic array. Latches one activation matrix and one weight matrix on start.
//  Pulses weights_load for one cycle, then streams activation rows into the array.
//  Skewed diagonally: column j is delayed j cycles, so partial sums meet their operands.
//  Optionally drains the pipeline with zeros, then reports done.
// PARAMETERS
//  DATA_WIDTH  8  operand width, signed
//  ARRAY_A_W   4  activation rows (vectors streamed)
//  ARRAY_A_L   4  activation columns = array input lanes
//  ARRAY_W_W   4  weight rows
//  ARRAY_W_L   4  weight columns; sets drain depth
// PORTS
//  clk            in   1                        clock, all state on rising edge
//  reset          in   1                        async, active-high; asynchronous assert, release synchronised outside
//  start          in   1                        request a run; sampled only in IDLE
//  input_matrix   in   DW x [A_W][A_L]          activations, captured on accepted start
//  weight_matrix  in   DW x [W_W][W_L]          weights, captured on accepted start
//  busy           out  1                        high from cycle after accepted start through done cycle
//  done           out  1                        one-cycle pulse, run complete
//  weights_load   out  1                        one-cycle pulse to array
//  weight_data    out  DW x [W_W][W_L]          latched weights, stable while busy
//  input_data     out  DW x [A_L]               skewed activation lanes to array
//  data_valid     out  1                        high during FEED cycles only
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; all outputs 0, including matrices and lanes.
//  FSM IDLE->LOAD->FEED->DRAIN->DONE->IDLE.
//   IDLE: start=1 latches both matrices and goes to LOAD.
//   LOAD: 1 cycle; weights_load=1, input_data=0.
//   FEED: cnt k=0..A_W+A_L-2; data_valid=1.
//    input_data[j] = input_matrix[k-j][j] when 0<=k-j<A_W, else 0.
//    After the last k, go to DRAIN.
//   DRAIN: ARRAY_W_L cycles; input_data=0, data_valid=0.
//   DONE: 1 cycle; done=1, busy=1. Next state IDLE.
//  Latency: start at cycle 0; weights_load at cycle 1; first lane data at cycle 2.
//   done arrives at cycle 2+(A_W+A_L-1)+ARRAY_W_L.
//  Timing: outputs are registered, no combinational path from start.
//   input_data is driven from the registered latch plus cnt.
//  start while busy (including the DONE cycle) is ignored; no queueing.
//   Inputs changing mid-run have no effect.
//  Zero padding: lanes are zero wherever k-j is outside [0,A_W).
//  cnt width: $clog2(A_W+A_L+ARRAY_W_L)+1. cnt clears on every state entry, no wrap.
//  Reset mid-run returns to IDLE in the same edge. No done is emitted and lanes go to 0.
// CONFIGURATION
//  SYS_FEEDER_DRAIN_EN defined: DRAIN state present, as above.
//  SYS_FEEDER_DRAIN_EN undefined: FEED->DONE directly.
//   done arrives at cycle 2+(A_W+A_L-1); the downstream collector owns the flush.
// STRUCTURE
//  Package sys_array_pkg:
//   typedef enum logic [2:0] feeder_state_t {IDLE,LOAD,FEED,DRAIN,DONE}
//   function feed_len(A_W,A_L) = A_W+A_L-1
//  Sub-module sys_feeder_ctrl: FSM plus cnt. Outputs state, cnt, busy, done, weights_load, data_valid.
//  The top holds the matrix latches and the skew mux.
// TESTING (A_W=A_L=W_W=W_L=4, DW=8)
//  1. Reset held, start=1 -> all outputs 0, state IDLE.
//  2. input_matrix[r][c]=r*4+c+1, start -> weights_load@1; FEED k=0 lanes {1,0,0,0}.
//     k=3 lanes {13,10,7,4}; k=6 lanes {0,0,0,16}.
//  3. DRAIN_EN: done at cycle 13; without the macro: done at cycle 9; busy high cycles 1..done.
//  4. start pulsed at cycles 3 and 13 (DONE) -> ignored; one done only. Fresh start @14 accepted.
//  5. reset asserted mid-FEED (k=2) -> next edge all outputs 0, no done.
//     New run after release behaves as test 2.
//  6. Matrices with -128 and 127, run through a golden sys_array_basic model -> matches A*W.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array feeder.
package sys_array_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feeder_state_t;

    // Number of skewed feed cycles needed to push every activation row through all lanes.
    function automatic int feed_len(input int a_w, input int a_l);
        return a_w + a_l - 1;
    endfunction

endpackage

// File: rtl/sys_feeder_ctrl.sv
// Feeder sequencing FSM and cycle counter; all control outputs are registered.
// The DRAIN phase exists only when SYS_FEEDER_DRAIN_EN is defined.
module sys_feeder_ctrl
    import sys_array_pkg::*;
#(
    parameter int ARRAY_A_W = 4,
    parameter int ARRAY_A_L = 4,
    parameter int ARRAY_W_L = 4,
    parameter int CNT_W     = $clog2(ARRAY_A_W + ARRAY_A_L + ARRAY_W_L) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output feeder_state_t    state,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             weights_load,
    output logic             data_valid
);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(feed_len(ARRAY_A_W, ARRAY_A_L) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
`ifdef SYS_FEEDER_DRAIN_EN
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARRAY_W_L - 1);
`endif

    feeder_state_t    state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             weights_load_r;
    logic             data_valid_r;

    // State, counter and registered control outputs, decided from the transition being taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            weights_load_r <= 1'b0;
            data_valid_r   <= 1'b0;
        end else begin
            done_r         <= 1'b0;
            weights_load_r <= 1'b0;
            data_valid_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r  <= '0;
                    busy_r <= start;
                    if (start) begin
                        state_r        <= LOAD;
                        weights_load_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    state_r      <= FEED;
                    cnt_r        <= '0;
                    busy_r       <= 1'b1;
                    data_valid_r <= 1'b1;
                end
                FEED: begin
                    busy_r <= 1'b1;
                    if (cnt_r == FEED_LAST) begin
                        cnt_r <= '0;
`ifdef SYS_FEEDER_DRAIN_EN
                        state_r <= DRAIN;
`else
                        state_r <= DONE;
                        done_r  <= 1'b1;
`endif
                    end else begin
                        state_r      <= FEED;
                        cnt_r        <= cnt_r + CNT_ONE;
                        data_valid_r <= 1'b1;
                    end
                end
`ifdef SYS_FEEDER_DRAIN_EN
                DRAIN: begin
                    busy_r <= 1'b1;
                    if (cnt_r == DRAIN_LAST) begin
                        state_r <= DONE;
                        cnt_r   <= '0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
`endif
                DONE: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign state        = state_r;
    assign cnt          = cnt_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign weights_load = weights_load_r;
    assign data_valid   = data_valid_r;

endmodule

// File: rtl/sys_array_feeder.sv
// Systolic-array feeder: latches activation/weight matrices on start and streams skewed lanes.
// Build option SYS_FEEDER_DRAIN_EN adds a zero-drain phase of ARRAY_W_L cycles before done.
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_A_W  = 4,
    parameter int ARRAY_A_L  = 4,
    parameter int ARRAY_W_W  = 4,
    parameter int ARRAY_W_L  = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0] input_matrix,
    input  logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] weight_matrix,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            weights_load,
    output logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] weight_data,
    output logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0]            input_data,
    output logic                                            data_valid
);

    localparam int CNT_W = $clog2(ARRAY_A_W + ARRAY_A_L + ARRAY_W_L) + 1;
    localparam int ROW_W = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1;

    feeder_state_t    state_s;
    logic [CNT_W-1:0] cnt_s;

    logic [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0] act_lat_r;
    logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] wgt_lat_r;
    logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0]                lanes_s;

    sys_feeder_ctrl #(
        .ARRAY_A_W (ARRAY_A_W),
        .ARRAY_A_L (ARRAY_A_L),
        .ARRAY_W_L (ARRAY_W_L),
        .CNT_W     (CNT_W)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .state        (state_s),
        .cnt          (cnt_s),
        .busy         (busy),
        .done         (done),
        .weights_load (weights_load),
        .data_valid   (data_valid)
    );

    // Matrix latches: captured only on the edge that accepts a start, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_lat_r <= '0;
            wgt_lat_r <= '0;
        end else if (state_s == IDLE && start) begin
            act_lat_r <= input_matrix;
            wgt_lat_r <= weight_matrix;
        end else begin
            act_lat_r <= act_lat_r;
            wgt_lat_r <= wgt_lat_r;
        end
    end

    // Diagonal skew: lane j carries row (cnt - j) while that row exists, zero elsewhere.
    always_comb begin
        lanes_s = '0;
        for (int j = 0; j < ARRAY_A_L; j++) begin
            if (state_s == FEED && int'(cnt_s) >= j && (int'(cnt_s) - j) < ARRAY_A_W) begin
                lanes_s[j] = act_lat_r[ROW_W'(int'(cnt_s) - j)][j];
            end else begin
                lanes_s[j] = {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign weight_data = wgt_lat_r;
    assign input_data  = lanes_s;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Self-checking bench for sys_array_feeder (4x4, 8-bit); honours SYS_FEEDER_DRAIN_EN.
module tb_sys_array_feeder;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int AL     = 4;
    localparam int WW     = 4;
    localparam int WL     = 4;
    localparam int FEED_N = AW + AL - 1;
`ifdef SYS_FEEDER_DRAIN_EN
    localparam int DONE_CYC = 2 + FEED_N + WL;
`else
    localparam int DONE_CYC = 2 + FEED_N;
`endif

    typedef logic [AW-1:0][AL-1:0][DW-1:0] amat_t;
    typedef logic [WW-1:0][WL-1:0][DW-1:0] wmat_t;
    typedef logic [AL-1:0][DW-1:0]         lanes_t;

    typedef struct {
        int     cyc;
        logic   wl;
        logic   dv;
        logic   dn;
        logic   bz;
        lanes_t lanes;
    } vec_t;

    logic   clk;
    logic   reset;
    logic   start;
    amat_t  input_matrix;
    wmat_t  weight_matrix;
    logic   busy;
    logic   done;
    logic   weights_load;
    wmat_t  weight_data;
    lanes_t input_data;
    logic   data_valid;

    int errors = 0;
    int checks = 0;

    logic   obs_wl    [0:31];
    logic   obs_dv    [0:31];
    logic   obs_dn    [0:31];
    logic   obs_bz    [0:31];
    lanes_t obs_lanes [0:31];

    sys_array_feeder #(
        .DATA_WIDTH (DW),
        .ARRAY_A_W  (AW),
        .ARRAY_A_L  (AL),
        .ARRAY_W_W  (WW),
        .ARRAY_W_L  (WL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .input_matrix  (input_matrix),
        .weight_matrix (weight_matrix),
        .busy          (busy),
        .done          (done),
        .weights_load  (weights_load),
        .weight_data   (weight_data),
        .input_data    (input_data),
        .data_valid    (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input int cyc, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s index %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic lanes_t mk_lanes(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [7:0] l3);
        lanes_t l;
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        return l;
    endfunction

    // Expected lanes at cycle c after acceptance: feed step k=c-2, lane j shows row k-j.
    function automatic lanes_t model_lanes(input amat_t a, input int c);
        lanes_t l;
        int k;
        k = c - 2;
        for (int j = 0; j < AL; j++) begin
            if (k >= 0 && k < FEED_N && (k - j) >= 0 && (k - j) < AW) l[j] = a[k - j][j];
            else l[j] = 8'h00;
        end
        return l;
    endfunction

    function automatic amat_t rand_amat();
        amat_t m;
        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AL; c++) m[r][c] = 8'($urandom);
        return m;
    endfunction

    function automatic wmat_t rand_wmat();
        wmat_t m;
        for (int r = 0; r < WW; r++)
            for (int c = 0; c < WL; c++) m[r][c] = 8'($urandom);
        return m;
    endfunction

    task automatic chk_all_zero(input string tag, input int cyc);
        chk_bit({tag, "_busy"}, cyc, busy, 1'b0);
        chk_bit({tag, "_done"}, cyc, done, 1'b0);
        chk_bit({tag, "_weights_load"}, cyc, weights_load, 1'b0);
        chk_bit({tag, "_data_valid"}, cyc, data_valid, 1'b0);
        chk_vec({tag, "_input_data"}, cyc, 128'(input_data), 128'h0);
        chk_vec({tag, "_weight_data"}, cyc, 128'(weight_data), 128'h0);
    endtask

    // One full run from start acceptance through the first idle cycle after done.
    task automatic run_check(input amat_t a, input wmat_t w, input bit p3, input bit pdone, input bit scramble);
        input_matrix  = a;
        weight_matrix = w;
        start         = 1'b1;
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            @(posedge clk); #1;
            start        = 1'b0;
            obs_wl[c]    = weights_load;
            obs_dv[c]    = data_valid;
            obs_dn[c]    = done;
            obs_bz[c]    = busy;
            obs_lanes[c] = input_data;
            chk_bit("weights_load", c, weights_load, c == 1);
            chk_bit("data_valid", c, data_valid, c >= 2 && c < 2 + FEED_N);
            chk_bit("done", c, done, c == DONE_CYC);
            chk_bit("busy", c, busy, c >= 1 && c <= DONE_CYC);
            chk_vec("input_data", c, 128'(input_data), 128'(model_lanes(a, c)));
            chk_vec("weight_data", c, 128'(weight_data), 128'(w));
            if (scramble) begin
                input_matrix  = rand_amat();
                weight_matrix = rand_wmat();
            end
            if ((p3 && c + 1 == 3) || (pdone && c + 1 == DONE_CYC)) start = 1'b1;
        end
    endtask

    // Rebuild A*W from the observed skewed stream and compare with the plain product.
    task automatic chk_product(input amat_t a, input wmat_t w);
        for (int r = 0; r < AW; r++) begin
            for (int n = 0; n < WL; n++) begin
                int acc_obs;
                int acc_exp;
                acc_obs = 0;
                acc_exp = 0;
                for (int j = 0; j < AL; j++) begin
                    acc_obs += int'($signed(obs_lanes[2 + r + j][j])) * int'($signed(w[j][n]));
                    acc_exp += int'($signed(a[r][j])) * int'($signed(w[j][n]));
                end
                chk_int("matmul", r * WL + n, acc_obs, acc_exp);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got no end, expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        amat_t seq_a;
        wmat_t seq_w;
        amat_t ext_a;
        wmat_t ext_w;
        vec_t  tbl [7];

        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AL; c++) seq_a[r][c] = 8'(r * 4 + c + 1);
        for (int r = 0; r < WW; r++)
            for (int c = 0; c < WL; c++) seq_w[r][c] = 8'(r * 16 + c + 100);

        tbl[0] = '{1,            1'b1, 1'b0, 1'b0, 1'b1, mk_lanes(8'd0, 8'd0, 8'd0, 8'd0)};
        tbl[1] = '{2,            1'b0, 1'b1, 1'b0, 1'b1, mk_lanes(8'd1, 8'd0, 8'd0, 8'd0)};
        tbl[2] = '{5,            1'b0, 1'b1, 1'b0, 1'b1, mk_lanes(8'd13, 8'd10, 8'd7, 8'd4)};
        tbl[3] = '{8,            1'b0, 1'b1, 1'b0, 1'b1, mk_lanes(8'd0, 8'd0, 8'd0, 8'd16)};
        tbl[4] = '{9,            1'b0, 1'b0, (DONE_CYC == 9) ? 1'b1 : 1'b0, 1'b1, mk_lanes(8'd0, 8'd0, 8'd0, 8'd0)};
        tbl[5] = '{DONE_CYC,     1'b0, 1'b0, 1'b1, 1'b1, mk_lanes(8'd0, 8'd0, 8'd0, 8'd0)};
        tbl[6] = '{DONE_CYC + 1, 1'b0, 1'b0, 1'b0, 1'b0, mk_lanes(8'd0, 8'd0, 8'd0, 8'd0)};

        // Reset held with start asserted: everything stays zero.
        reset         = 1'b1;
        start         = 1'b1;
        input_matrix  = rand_amat();
        weight_matrix = rand_wmat();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_all_zero("reset", i);
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("post_reset", 0);

        // Directed run, checked cycle by cycle and against the vector table.
        run_check(seq_a, seq_w, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk_bit("tbl_weights_load", tbl[i].cyc, obs_wl[tbl[i].cyc], tbl[i].wl);
            chk_bit("tbl_data_valid", tbl[i].cyc, obs_dv[tbl[i].cyc], tbl[i].dv);
            chk_bit("tbl_done", tbl[i].cyc, obs_dn[tbl[i].cyc], tbl[i].dn);
            chk_bit("tbl_busy", tbl[i].cyc, obs_bz[tbl[i].cyc], tbl[i].bz);
            chk_vec("tbl_lanes", tbl[i].cyc, 128'(obs_lanes[tbl[i].cyc]), 128'(tbl[i].lanes));
        end

        // Starts at cycle 3 and on the done cycle are ignored; inputs scrambled mid-run.
        run_check(seq_a, seq_w, 1'b1, 1'b1, 1'b1);
        // Fresh start in the first idle cycle is accepted.
        run_check(rand_amat(), rand_wmat(), 1'b0, 1'b0, 1'b0);

        // Reset in the middle of FEED (k=2).
        input_matrix  = seq_a;
        weight_matrix = seq_w;
        start         = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk_vec("pre_abort_lanes", 4, 128'(input_data), 128'(model_lanes(seq_a, 4)));
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("abort", 0);
        reset = 1'b0;
        for (int i = 1; i <= DONE_CYC + 2; i++) begin
            @(posedge clk); #1;
            chk_all_zero("abort_idle", i);
        end
        run_check(seq_a, seq_w, 1'b0, 1'b0, 1'b0);

        // Extremes and random matrices: rebuilt product must equal A*W.
        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AL; c++) ext_a[r][c] = ((r + c) % 2 == 0) ? 8'h80 : 8'h7F;
        for (int r = 0; r < WW; r++)
            for (int c = 0; c < WL; c++) ext_w[r][c] = (r == c) ? 8'h80 : 8'h7F;
        run_check(ext_a, ext_w, 1'b0, 1'b0, 1'b0);
        chk_product(ext_a, ext_w);
        for (int t = 0; t < 6; t++) begin
            amat_t ra;
            wmat_t rw;
            ra = rand_amat();
            rw = rand_wmat();
            ra[0][0] = 8'h80;
            rw[WW-1][WL-1] = 8'h7F;
            run_check(ra, rw, 1'b0, 1'b0, (t % 2) == 1);
            chk_product(ra, rw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
